// File: rtl/fsm_pkg.sv
// Shared definitions for the serial-stream FSM blocks: polarity encodings and
// the run-length legality check used at elaboration time.
// Latency: n/a (package). Backpressure: n/a (package).
package fsm_pkg;

  // Polarity select: bit 0 enables runs of ones, bit 1 enables runs of zeros.
  typedef enum logic [1:0] {
    POL_NONE  = 2'b00,
    POL_ONES  = 2'b01,
    POL_ZEROS = 2'b10,
    POL_BOTH  = 2'b11
  } pol_e;

  localparam int RUN_LEN_MIN = 2;
  localparam int RUN_LEN_MAX = 255;

  // Below two there is no "run"; above 255 the counter width assumptions break.
  function automatic bit run_len_ok(input int n);
    return (n >= RUN_LEN_MIN) && (n <= RUN_LEN_MAX);
  endfunction

  // Mask for a completed run of bit b under polarity select pol.
  function automatic logic pol_pass(input logic [1:0] pol, input logic b);
    return b ? pol[0] : pol[1];
  endfunction

endpackage

// File: rtl/mealy_run_detector_if.sv
// Bundle of the serial input, run-time controls and detector outputs.
// Latency: n/a (wiring only). Backpressure: none, the stream is qualified by en.
// master: stream source / control side; slave: the detector.
interface mealy_run_detector_if #(
  parameter int CNT_W = 8
);
  logic             x;
  logic             en;
  logic [1:0]       pol;
  logic             ovl;
  logic             clr_cnt;
  logic             y;
  logic             y_q;
  logic             y_bit;
  logic [CNT_W-1:0] det_cnt;

  modport master (
    output x, en, pol, ovl, clr_cnt,
    input  y, y_q, y_bit, det_cnt
  );

  modport slave (
    input  x, en, pol, ovl, clr_cnt,
    output y, y_q, y_bit, det_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count reflects inc one clock later. Backpressure: none, holds at all-ones.
// Ports: clk, rst_n (async active-low), inc, clr, cnt[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mealy_run_detector.sv
// Mealy detector flagging the bit that completes a run of RUN_LEN identical bits.
// Latency: y combinational (0 clk); y_q and det_cnt 1 clk after y.
// Backpressure: none; bits are consumed only when en=1, state frozen otherwise.
// Ports: clk, rst (async active-low), bus (slave): x, en, pol, ovl, clr_cnt in;
//        y, y_q, y_bit, det_cnt out.
module mealy_run_detector
  import fsm_pkg::*;
#(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8,
  parameter int RC_W    = $clog2(RUN_LEN)
) (
  input logic                  clk,
  input logic                  rst,
  mealy_run_detector_if.slave  bus
);

  if (!run_len_ok(RUN_LEN)) begin : g_bad_run_len
    $error("mealy_run_detector: RUN_LEN must be in 2..255");
  end
  if (RC_W != $clog2(RUN_LEN)) begin : g_bad_rc_w
    $error("mealy_run_detector: RC_W is derived from RUN_LEN");
  end

  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RUN_LEN - 1);

  logic            lb, lb_nxt;   // last consumed bit
  logic [RC_W-1:0] rc, rc_nxt;   // length of current run; 0 = no history
  logic            y_q_r;
  logic            match;
  logic            y;

  // The current bit would be the RUN_LEN-th of a run.
  assign match = (rc != '0) && (bus.x == lb) && (rc == RC_MAX);
  // Polarity only masks the flag; the run tracker ignores it.
  assign y     = bus.en && match && pol_pass(bus.pol, bus.x);

  always_comb begin
    lb_nxt = lb;
    rc_nxt = rc;
    if (bus.en) begin
      if ((rc == '0) || (bus.x != lb)) begin
        lb_nxt = bus.x;
        rc_nxt = RC_W'(1);
      end else if (!match) begin
        rc_nxt = rc + RC_W'(1);
      end else if (!bus.ovl) begin
        // Non-overlapping: the completing bit is consumed by this run.
        rc_nxt = '0;
      end
      // match with ovl=1: rc stays at RC_MAX so each further equal bit detects.
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lb    <= 1'b0;
      rc    <= '0;
      y_q_r <= 1'b0;
    end else begin
      lb    <= lb_nxt;
      rc    <= rc_nxt;
      y_q_r <= y;
    end
  end

  sat_counter #(.W(CNT_W)) u_det_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (y),
    .clr   (bus.clr_cnt),
    .cnt   (bus.det_cnt)
  );

  assign bus.y     = y;
  assign bus.y_q   = y_q_r;
  assign bus.y_bit = bus.x;

endmodule

// File: doc/mealy_run_detector.md
# mealy_run_detector

Parametrised Mealy run-length detector, the successor to the fixed 111/000 overlapping detector. It flags the cycle in which a run of `RUN_LEN` identical bits completes on the serial input `x`. Polarity (ones, zeros, both) and overlap mode are selectable at run time. It adds an input-valid qualifier, a registered copy of the flag and a saturating detection counter, and sits directly on a serial bit stream in front of FSM-level control logic.

## Interface
- `RUN_LEN`, default 3: run length to detect; legal range 2..255.
- `CNT_W`, default 8: width of the detection counter.
- `RC_W`, default `$clog2(RUN_LEN)`: width of the internal run counter. It is derived and must not be overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. When low, all state and registered outputs clear immediately.
- `x`  in  1  serial data bit.
- `en`  in  1  bit-valid. A bit is consumed only when `en`=1 at a rising edge.
- `pol`  in  2  polarity select: 2'b01 = ones only, 2'b10 = zeros only, 2'b11 = both, 2'b00 = detection disabled.
- `ovl`  in  1  1 = overlapping, 0 = non-overlapping.
- `clr_cnt`  in  1  synchronous clear of `det_cnt`.
- `y`  out  1  Mealy detect flag, combinational from state and inputs.
- `y_q`  out  1  `y` registered: one-cycle-delayed copy.
- `y_bit`  out  1  polarity of the run that produced `y` (equals `x`); valid only while `y`=1.
- `det_cnt`  out  CNT_W  saturating count of detections.

## Operation
- State registers:
  - `lb`: last bit.
  - `rc`: run count, 0..RUN_LEN-1. `rc`=0 means there is no history.
- `match` = (`rc` != 0) & (`x` == `lb`) & (`rc` == RUN_LEN-1).
- `pol_ok` = (`x` ? `pol[0]` : `pol[1]`).
- `y` = `en` & `match` & `pol_ok`.
- State update, only when `en`=1:
  - `rc`=0: `lb`<=`x`, `rc`<=1.
  - `x`!=`lb`: `lb`<=`x`, `rc`<=1.
  - `x`==`lb` and not `match`: `rc`<=`rc`+1.
  - `match` and `ovl`=1: `rc` holds at RUN_LEN-1, so every further identical bit detects again.
  - `match` and `ovl`=0: `rc`<=0, so the next bit starts a fresh run.
- The run counter advances independently of `pol`. A disabled polarity only masks `y`. Consequence: in non-overlap mode a masked completion still restarts the run.
- `en`=0: state frozen, `y`=0, `y_q` loads 0 on the next edge.
- `det_cnt`:
  - `clr_cnt`=1: loads 0. This has priority over an increment in the same cycle.
  - Else, if `y`=1 and `det_cnt` != all-ones: `det_cnt`+1.
  - At all-ones it holds; there is no wrap.
- `pol` and `ovl` are sampled every cycle and take effect on the cycle they are presented. There is no internal latching.

## Timing
- Reset values: `lb`=0, `rc`=0, `y_q`=0, `det_cnt`=0. `y`=0 whenever `rc`=0, so `y` is also 0 during reset.
- `y` has zero latency: it is asserted in the same cycle as the completing bit, before the capturing edge.
- `y_q` lags `y` by exactly 1 clock.
- `det_cnt` reflects a detection 1 clock after `y`.
- The first detection after reset needs at least RUN_LEN consecutive valid identical bits.
- Reset asserted mid-run clears history. After `rst` rises, a full RUN_LEN run is required again.
- No combinational path from `x` to `y_q` or `det_cnt`.

## Structure
- Shared package `fsm_pkg` holds:
  - polarity encodings `POL_NONE`, `POL_ONES`, `POL_ZEROS`, `POL_BOTH`;
  - the `RUN_LEN` legality check (elaboration-time assertion, RUN_LEN >= 2).
- One sub-module: `sat_counter`, parametrised on width, with inputs `inc` and `clr` and an async active-low reset. It is instantiated for `det_cnt`.
- Run tracker and output logic stay in `mealy_run_detector`.

## Test plan
- RUN_LEN=3, `ovl`=1, `pol`=11, `en`=1. Stimulus: 0,0,0,0 then eight 1s then 0,0,0,0.
  - Response: `y`=1 on the 3rd and 4th 0, on the 3rd–8th 1 and on the 3rd–4th trailing 0.
  - `det_cnt`=10 at the end.
- Same stream with `ovl`=0.
  - Response: `y` on the 3rd 0, the 3rd and 6th 1, and the 3rd trailing 0.
  - `det_cnt`=4.
- `pol`=01, `ovl`=1, RUN_LEN=4. Stimulus: 0000 1111 1.
  - Response: zeros masked; `y`=1 only on the 4th and 5th 1; `y_bit`=1 each time.
- `en` gaps: RUN_LEN=3. Stimulus: 1, `en`=0 for 5 clocks with `x` toggling, then 1, 1.
  - Response: `y` on the final 1 only; state unchanged across the gap.
- Reset mid-run: after 1,1, pulse `rst` low between edges, then 1.
  - Response: no detect; `det_cnt`=0; `y_q`=0 immediately.
  - Two more 1s then give `y`=1.
- Saturation and clear: CNT_W=2, `ovl`=1, RUN_LEN=2, six 1s.
  - Response: `det_cnt` reaches 3 and holds.
  - `clr_cnt`=1 together with `y`=1 gives `det_cnt`=0 next cycle.
